rll_keyed_gate_array: RTL and testbench

Parametrised random-logic-locking key-gate stage with on-chip sequential key loading. A serially loaded shadow key register is committed atomically to an active key. The active key drives an array of XOR/XNOR key gates applied to a registered valid/ready data path. It sits between an unlocked logic cone's internal wires and their fan-out, replacing the fixed 16-input combinational key-gate layer of the previous generation.

---
 rtl/rll_keyed_gate_array_pkg.sv | 16 +
 rtl/rll_keyed_gate_array_if.sv | 11 +
 rtl/rll_keyed_gate_array_key_shifter.sv | 81 ++++++++
 rtl/rll_keyed_gate_array.sv | 69 ++++++
 tb/tb_rll_keyed_gate_array.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rll_keyed_gate_array_pkg.sv
// Shared types and helpers for the keyed gate array and its key loader.
package rll_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2,
    ARMED   = 2'd3
  } key_state_e;

  // Width of a counter that must hold the values 0..key_w inclusive.
  function automatic int cnt_width(input int key_w);
    return $clog2(key_w + 1);
  endfunction

endpackage

// File: rtl/rll_keyed_gate_array_if.sv
// Valid/ready beat bus used on both sides of the key-gate stage.
interface rll_keyed_gate_array_if #(
  parameter int DATA_W = 19
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rll_keyed_gate_array_key_shifter.sv
// Serial key loader: shadow shift register, bit counter, load FSM,
// atomic shadow-to-active commit and rejected-commit pulse.
module rll_key_shifter
  import rll_pkg::*;
#(
  parameter int KEY_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_sdi,
  input  logic                        key_shift,
  input  logic                        key_commit,
  output logic [cnt_width(KEY_W)-1:0] key_cnt,
  output logic                        key_loaded,
  output logic                        key_err,
  output logic [KEY_W-1:0]            active_key
);

  localparam int CNT_W = cnt_width(KEY_W);

  key_state_e       state_q, state_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] active_q;
  logic             loaded_q;
  logic             err_q;
  logic             commit_ok;
  logic             commit_bad;
  logic             cnt_full;
  logic             cnt_last;

  assign cnt_full   = (cnt_q == CNT_W'(KEY_W));
  assign cnt_last   = (cnt_q == CNT_W'(KEY_W - 1));
  assign commit_ok  = key_commit && !key_shift && (state_q == FULL);
  assign commit_bad = key_commit && !commit_ok;

  // Next-state, counter and shadow update; a commit never coincides with a shift.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (commit_ok) begin
      state_d = ARMED;
      cnt_d   = '0;
    end else if (key_shift) begin
      shadow_d             = shadow_q >> 1;
      shadow_d[KEY_W-1]    = key_sdi;
      if (!cnt_full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      state_d = (cnt_full || cnt_last) ? FULL : LOADING;
    end
  end

  // Key loader state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      shadow_q <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      err_q    <= commit_bad;
      if (commit_ok) begin
        active_q <= shadow_q;
        loaded_q <= 1'b1;
      end
    end
  end

  assign key_cnt    = cnt_q;
  assign key_loaded = loaded_q;
  assign key_err    = err_q;
  assign active_key = active_q;

endmodule

// File: rtl/rll_keyed_gate_array.sv
// Key-gate stage: XOR/XNOR gates keyed by the committed active key, applied
// to a single registered valid/ready beat. Upper data bits pass ungated.
module rll_keyed_gate_array
  import rll_pkg::*;
#(
  parameter int               KEY_W    = 16,
  parameter int               DATA_W   = 19,
  parameter logic [KEY_W-1:0] GATE_POL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_sdi,
  input  logic                        key_shift,
  input  logic                        key_commit,
  output logic [cnt_width(KEY_W)-1:0] key_cnt,
  output logic                        key_loaded,
  output logic                        key_err,
  rll_keyed_gate_array_if.slave       in_bus,
  rll_keyed_gate_array_if.master      out_bus
);

  logic [KEY_W-1:0]  active_key;
  logic [DATA_W-1:0] key_mask;
  logic [DATA_W-1:0] gated;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              accept;

  rll_key_shifter #(
    .KEY_W (KEY_W)
  ) u_key_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_sdi    (key_sdi),
    .key_shift  (key_shift),
    .key_commit (key_commit),
    .key_cnt    (key_cnt),
    .key_loaded (key_loaded),
    .key_err    (key_err),
    .active_key (active_key)
  );

  // Gate array: XNOR gates are XOR gates with the polarity bit folded into the key.
  always_comb begin
    key_mask              = '0;
    key_mask[KEY_W-1:0]   = active_key ^ GATE_POL;
    gated                 = in_bus.data ^ key_mask;
  end

  assign in_bus.ready = !valid_q || out_bus.ready;
  assign accept       = in_bus.valid && in_bus.ready;

  // Single output register; holds its beat while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= gated;
    end else if (out_bus.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_bus.valid = valid_q;
  assign out_bus.data  = data_q;

endmodule

// File: tb/tb_rll_keyed_gate_array.sv
// Directed bench for rll_keyed_gate_array: one instance with XOR gates and
// one with XNOR gates, both fed identical key and data stimulus.
module tb_rll_keyed_gate_array;

  localparam int KEY_W  = 16;
  localparam int DATA_W = 19;
  localparam int CNT_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             key_sdi;
  logic             key_shift;
  logic             key_commit;
  logic [CNT_W-1:0] key_cnt, key_cnt2;
  logic             key_loaded, key_loaded2;
  logic             key_err, key_err2;

  int n_checks = 0;
  int n_fail   = 0;

  rll_keyed_gate_array_if #(.DATA_W(DATA_W)) in_bus  ();
  rll_keyed_gate_array_if #(.DATA_W(DATA_W)) out_bus ();
  rll_keyed_gate_array_if #(.DATA_W(DATA_W)) in_bus2 ();
  rll_keyed_gate_array_if #(.DATA_W(DATA_W)) out_bus2 ();

  rll_keyed_gate_array #(
    .KEY_W    (KEY_W),
    .DATA_W   (DATA_W),
    .GATE_POL (16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_sdi    (key_sdi),
    .key_shift  (key_shift),
    .key_commit (key_commit),
    .key_cnt    (key_cnt),
    .key_loaded (key_loaded),
    .key_err    (key_err),
    .in_bus     (in_bus),
    .out_bus    (out_bus)
  );

  rll_keyed_gate_array #(
    .KEY_W    (KEY_W),
    .DATA_W   (DATA_W),
    .GATE_POL (16'hFFFF)
  ) dut_xnor (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_sdi    (key_sdi),
    .key_shift  (key_shift),
    .key_commit (key_commit),
    .key_cnt    (key_cnt2),
    .key_loaded (key_loaded2),
    .key_err    (key_err2),
    .in_bus     (in_bus2),
    .out_bus    (out_bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [DATA_W-1:0] d);
    in_bus.valid  = v;
    in_bus.data   = d;
    in_bus2.valid = v;
    in_bus2.data  = d;
  endtask

  task automatic drive_ready(input logic r);
    out_bus.ready  = r;
    out_bus2.ready = r;
  endtask

  task automatic shift_bit(input logic b);
    key_sdi   = b;
    key_shift = 1'b1;
    tick();
    key_shift = 1'b0;
  endtask

  task automatic load_bits(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) shift_bit(k[i]);
  endtask

  task automatic beat(input logic [DATA_W-1:0] d);
    drive_in(1'b1, d);
    tick();
    drive_in(1'b0, '0);
  endtask

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_front;
  int sent;
  int got;

  initial begin
    rst_n      = 1'b0;
    key_sdi    = 1'b0;
    key_shift  = 1'b0;
    key_commit = 1'b0;
    drive_in(1'b0, '0);
    drive_ready(1'b1);
    tick();
    tick();
    check("rst_key_cnt",    32'(key_cnt),        32'd0);
    check("rst_key_loaded", 32'(key_loaded),     32'd0);
    check("rst_key_err",    32'(key_err),        32'd0);
    check("rst_out_valid",  32'(out_bus.valid),  32'd0);
    check("rst_out_data",   32'(out_bus.data),   32'd0);
    check("rst_in_ready",   32'(in_bus.ready),   32'd1);
    check("rst_key_cnt2",   32'(key_cnt2),       32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Locked behaviour: key 0, three back-to-back beats.
    drive_in(1'b1, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lock_valid",      32'(out_bus.valid),  32'd1);
      check("lock_data_xor",   32'(out_bus.data),   32'h00000);
      check("lock_data_xnor",  32'(out_bus2.data),  32'h0FFFF);
      check("lock_in_ready",   32'(in_bus.ready),   32'd1);
    end
    drive_in(1'b0, '0);
    tick();
    check("lock_drain_valid", 32'(out_bus.valid), 32'd0);
    check("lock_key_loaded",  32'(key_loaded),    32'd0);

    // Premature commit after 10 shifts, twice in a row.
    load_bits(16'h1234, 10);
    check("part_cnt", 32'(key_cnt), 32'd10);
    key_commit = 1'b1;
    tick();
    check("rej_err_1", 32'(key_err), 32'd1);
    tick();
    key_commit = 1'b0;
    check("rej_err_2", 32'(key_err), 32'd1);
    tick();
    check("rej_err_end",  32'(key_err),    32'd0);
    check("rej_loaded",   32'(key_loaded), 32'd0);
    check("rej_cnt",      32'(key_cnt),    32'd10);

    // Full key 0x1234 (oldest bits drop out), commit with a beat in the same edge.
    load_bits(16'h1234, 16);
    check("full_cnt", 32'(key_cnt), 32'd16);
    key_commit = 1'b1;
    drive_in(1'b1, '0);
    tick();
    key_commit = 1'b0;
    check("commit_cnt",      32'(key_cnt),       32'd0);
    check("commit_loaded",   32'(key_loaded),    32'd1);
    check("commit_err",      32'(key_err),       32'd0);
    check("commit_old_key",  32'(out_bus.data),  32'h00000);
    check("commit_old_key2", 32'(out_bus2.data), 32'h0FFFF);
    drive_in(1'b1, 19'h7FFFF);
    tick();
    drive_in(1'b0, '0);
    check("key1234_xor",  32'(out_bus.data),  32'h7EDCB);
    check("key1234_xnor", 32'(out_bus2.data), 32'h71234);
    tick();

    // Shift and commit together in FULL: shift happens, commit rejected.
    load_bits(16'hAAAA, 16);
    key_sdi    = 1'b1;
    key_shift  = 1'b1;
    key_commit = 1'b1;
    tick();
    key_shift  = 1'b0;
    key_commit = 1'b0;
    check("simul_err", 32'(key_err), 32'd1);
    check("simul_cnt", 32'(key_cnt), 32'd16);
    beat('0);
    check("simul_key_kept", 32'(out_bus.data), 32'h01234);
    check("simul_err_end",  32'(key_err),      32'd0);
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    check("d555_cnt", 32'(key_cnt), 32'd0);
    check("d555_err", 32'(key_err), 32'd0);
    beat('0);
    check("d555_data", 32'(out_bus.data), 32'h0D555);
    // Commit while ARMED is rejected.
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    check("armed_rej_err", 32'(key_err), 32'd1);
    tick();

    // Backpressure: stall 5 cycles, then drain; key is 0xD555.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      drive_ready(c >= 6);
      drive_in(sent < 5, 19'h40000 + DATA_W'(sent) * 19'h111);
      #1;
      if (c >= 1 && c <= 5) begin
        exp_front = exp_q[0];
        check("bp_in_ready", 32'(in_bus.ready),  32'd0);
        check("bp_hold",     32'(out_bus.data),  32'(exp_front));
      end
      if (out_bus.valid && out_bus.ready) begin
        if (exp_q.size() == 0) begin
          check("bp_unexpected", 32'(out_bus.data), 32'hDEAD);
        end else begin
          exp_front = exp_q.pop_front();
          check("bp_order", 32'(out_bus.data), 32'(exp_front));
          got++;
        end
      end
      if (in_bus.valid && in_bus.ready) begin
        exp_q.push_back(in_bus.data ^ 19'h0D555);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    drive_in(1'b0, '0);
    drive_ready(1'b1);
    check("bp_delivered", 32'(got), 32'd5);
    tick();
    check("bp_drained", 32'(out_bus.valid), 32'd0);

    // XNOR gates with all-ones key pass data unchanged.
    load_bits(16'hFFFF, 16);
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    beat(19'h2A5C3);
    check("ffff_xnor", 32'(out_bus2.data), 32'h2A5C3);
    check("ffff_xor",  32'(out_bus.data),  32'h25A3C);
    tick();

    // Asynchronous reset mid-load with a beat stalled in the output register.
    load_bits(16'h0015, 5);
    drive_ready(1'b0);
    drive_in(1'b1, 19'h12345);
    tick();
    drive_in(1'b0, '0);
    check("pre_rst_valid",  32'(out_bus.valid), 32'd1);
    check("pre_rst_cnt",    32'(key_cnt),       32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_key_cnt",    32'(key_cnt),       32'd0);
    check("arst_key_loaded", 32'(key_loaded),    32'd0);
    check("arst_key_err",    32'(key_err),       32'd0);
    check("arst_out_valid",  32'(out_bus.valid), 32'd0);
    check("arst_out_data",   32'(out_bus.data),  32'd0);
    check("arst_in_ready",   32'(in_bus.ready),  32'd1);
    drive_ready(1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    beat(19'h00000);
    check("post_rst_xor",  32'(out_bus.data),  32'h00000);
    check("post_rst_xnor", 32'(out_bus2.data), 32'h0FFFF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
